// File: rtl/adder_pkg.sv
// Shared types and default sizes for the multiword adder controller.
package adder_pkg;

   localparam int unsigned DefaultWidth = 4;
   localparam int unsigned DefaultWords = 4;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

endpackage

// File: rtl/adder_slice.sv
// Combinational WIDTH-bit slice adder: {carry, sum} = a + b + cin.
module adder_slice
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Serial multiword adder: one WIDTH-bit slice per RUN cycle, low slice first.
// Define ADDER_SUB_EN to add a 'sub' port selecting A - B.
module multiword_adder_ctrl
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned WORDS = DefaultWords
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*WORDS-1:0] op_a,
   input  logic [WIDTH*WORDS-1:0] op_b,
   input  logic                   cin,
`ifdef ADDER_SUB_EN
   input  logic                   sub,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*WORDS-1:0] result,
   output logic                   cout,
   output logic                   busy
);

   localparam int unsigned N    = WIDTH * WORDS;
   localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

   state_e            state_q, state_d;
   logic [N-1:0]      a_q, a_d;
   logic [N-1:0]      b_q, b_d;
   logic [N-1:0]      result_q, result_d;
   logic              carry_q, carry_d;
   logic [IdxW-1:0]   idx_q, idx_d;

   logic [N-1:0]      b_in;
   logic              c_in;
   logic [WIDTH-1:0]  slice_a, slice_b, slice_sum;
   logic              slice_carry;

   // Subtraction is folded into the captured operand: A + ~B + 1.
`ifdef ADDER_SUB_EN
   assign b_in = sub ? ~op_b : op_b;
   assign c_in = sub ? 1'b1 : cin;
`else
   assign b_in = op_b;
   assign c_in = cin;
`endif

   assign slice_a = a_q[int'(idx_q) * WIDTH +: WIDTH];
   assign slice_b = b_q[int'(idx_q) * WIDTH +: WIDTH];

   adder_slice #(
      .WIDTH (WIDTH)
   ) u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .cin   (carry_q),
      .sum   (slice_sum),
      .carry (slice_carry)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d      = op_a;
               b_d      = b_in;
               carry_d  = c_in;
               idx_d    = '0;
               result_d = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            busy = 1'b1;
            result_d[int'(idx_q) * WIDTH +: WIDTH] = slice_sum;
            carry_d = slice_carry;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
      end
   end

   assign result = result_q;
   assign cout   = carry_q;

endmodule
